mat_trans_stream_ctrl: RTL and testbench

Streaming controller that sequences a combinational NxN matrix transpose core. Fixed-point elements arrive one per beat on a valid/ready input stream, in row-major order, and are collected into an input buffer. Each full matrix is transposed into an output buffer, which is then emitted row-major on a valid/ready output stream. Ping-pong buffering lets the next matrix load while the current one emits. The block sits between the navigation matrix pipeline stages and the transpose datapath.

---
 rtl/mat_trans_stream_ctrl_pkg.sv | 25 ++
 rtl/mat_trans_core.sv | 19 +
 rtl/mat_trans_stream_ctrl.sv | 157 +++++++++++++++
 tb/tb_mat_trans_stream_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_trans_stream_ctrl_pkg.sv
// Shared types and helpers for the streaming matrix transpose controller.
package mat_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } in_state_e;

    typedef enum logic {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } out_state_e;

    // Width of a counter addressing all n*n elements, never narrower than one bit.
    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n * n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int idx(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/mat_trans_core.sv
// Purely combinational NxN transpose of a flat row-major element vector.
module mat_trans_core
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int MATRIX_SIZE = 3
) (
    input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_in,
    output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] mat_out
);

    for (genvar r = 0; r < MATRIX_SIZE; r++) begin : g_row
        for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
            assign mat_out[idx(r, c, MATRIX_SIZE)*DATA_WIDTH +: DATA_WIDTH] =
                   mat_in[idx(c, r, MATRIX_SIZE)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/mat_trans_stream_ctrl.sv
// Ping-pong stream controller around mat_trans_core: row-major in, transposed row-major out.
// Optional MAT_TRANS_CTRL_BYPASS_EN adds cfg_bypass/bypass_active for identity pass-through.
module mat_trans_stream_ctrl
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy
`ifdef MAT_TRANS_CTRL_BYPASS_EN
    ,
    input  logic                  cfg_bypass,
    output logic                  bypass_active
`endif
);

    localparam int NN = MATRIX_SIZE * MATRIX_SIZE;
    localparam int IW = idx_width(MATRIX_SIZE);
    localparam int BW = NN * DATA_WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

    // Element values are opaque here; BIN_POS only has to describe a valid format.
    if (BIN_POS < 0 || BIN_POS >= DATA_WIDTH || MATRIX_SIZE < 2 || MATRIX_SIZE > 8) begin : g_param_err
        $error("mat_trans_stream_ctrl: illegal BIN_POS or MATRIX_SIZE");
    end

    in_state_e  in_state_q,  in_state_d;
    out_state_e out_state_q, out_state_d;
    logic [IW-1:0] in_idx_q,  in_idx_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [BW-1:0] in_buf_q,  in_buf_d;
    logic [BW-1:0] out_buf_q, out_buf_d;
    logic [BW-1:0] trans_buf;
    logic          in_fire, out_fire, out_done, xfer;

    mat_trans_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .MATRIX_SIZE(MATRIX_SIZE)
    ) u_core (
        .mat_in (in_buf_q),
        .mat_out(trans_buf)
    );

    assign in_ready  = (in_state_q == FILL);
    assign out_valid = (out_state_q == EMIT);
    assign out_last  = out_valid && (out_idx_q == LAST_IDX);
    assign busy      = (in_idx_q != '0) || (in_state_q == FULL) || (out_state_q == EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_done  = out_fire && (out_idx_q == LAST_IDX);
    // A full input matrix moves across as soon as the output side is free or frees up this edge.
    assign xfer      = (in_state_q == FULL) && ((out_state_q == EMPTY) || out_done);

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NN; i++) begin
            if (out_valid && out_idx_q == IW'(i)) begin
                out_data = out_buf_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        in_idx_d   = in_idx_q;
        in_buf_d   = in_buf_q;
        case (in_state_q)
            FILL: begin
                if (in_fire) begin
                    for (int i = 0; i < NN; i++) begin
                        if (in_idx_q == IW'(i)) begin
                            in_buf_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
                        end
                    end
                    if (in_idx_q == LAST_IDX) begin
                        in_state_d = FULL;
                        in_idx_d   = '0;
                    end else begin
                        in_idx_d = in_idx_q + 1'b1;
                    end
                end
            end
            FULL: begin
                if (xfer) begin
                    in_state_d = FILL;
                end
            end
            default: in_state_d = FILL;
        endcase
    end

`ifdef MAT_TRANS_CTRL_BYPASS_EN
    logic bypass_q, bypass_d;

    assign bypass_active = bypass_q;
    assign bypass_d      = xfer ? cfg_bypass : bypass_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
        end
    end
`endif

    always_comb begin
        out_state_d = out_state_q;
        out_idx_d   = out_idx_q;
        out_buf_d   = out_buf_q;
        if (xfer) begin
`ifdef MAT_TRANS_CTRL_BYPASS_EN
            out_buf_d = cfg_bypass ? in_buf_q : trans_buf;
`else
            out_buf_d = trans_buf;
`endif
            out_state_d = EMIT;
            out_idx_d   = '0;
        end else if (out_fire) begin
            if (out_idx_q == LAST_IDX) begin
                out_state_d = EMPTY;
                out_idx_d   = '0;
            end else begin
                out_idx_d = out_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_state_q  <= FILL;
            out_state_q <= EMPTY;
            in_idx_q    <= '0;
            out_idx_q   <= '0;
            in_buf_q    <= '0;
            out_buf_q   <= '0;
        end else begin
            in_state_q  <= in_state_d;
            out_state_q <= out_state_d;
            in_idx_q    <= in_idx_d;
            out_idx_q   <= out_idx_d;
            in_buf_q    <= in_buf_d;
            out_buf_q   <= out_buf_d;
        end
    end

endmodule

// File: tb/tb_mat_trans_stream_ctrl.sv
// Randomized self-checking bench for mat_trans_stream_ctrl (N=3) against a queue-based transpose model.
module tb_mat_trans_stream_ctrl;

    localparam int DW = 16;
    localparam int N  = 3;
    localparam int NN = N * N;

    typedef logic [DW-1:0] mat_t [NN];

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
`ifdef MAT_TRANS_CTRL_BYPASS_EN
    logic          cfg_bypass;
    logic          bypass_active;
`endif

    int checks = 0;
    int errors = 0;

    int readyMode;
    logic bubbleChk;

    logic [DW-1:0] inMat [NN];
    int            inCnt;
    int            outCnt;
    logic [DW-1:0] expData [$];
    logic          expLast [$];
    logic          expByp  [$];

    logic          prevStall;
    logic [DW-1:0] prevData;
    logic          prevLast;
    logic          gapActive;
    int            gapCnt;

    mat_trans_stream_ctrl #(
        .DATA_WIDTH (DW),
        .BIN_POS    (8),
        .MATRIX_SIZE(N)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy)
`ifdef MAT_TRANS_CTRL_BYPASS_EN
        ,
        .cfg_bypass   (cfg_bypass),
        .bypass_active(bypass_active)
`endif
    );

    always #5 clk = ~clk;

    // Downstream readiness: 0 = always ready, 1 = stalled, otherwise random.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic modelBypass();
`ifdef MAT_TRANS_CTRL_BYPASS_EN
        return cfg_bypass;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: output (r,c) is input (c,r), or the input itself when bypassing.
    function automatic void pushMatrix();
        logic byp;
        byp = modelBypass();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                expData.push_back(byp ? inMat[r*N+c] : inMat[c*N+r]);
                expLast.push_back(r == N-1 && c == N-1);
                expByp.push_back(byp);
            end
        end
    endfunction

    // Monitor: sampled on the falling edge, predicting the transfers of the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            inCnt     = 0;
            prevStall = 1'b0;
            gapActive = 1'b0;
            expData.delete();
            expLast.delete();
            expByp.delete();
        end else begin
            if (prevStall) begin
                checkOutput("bp_valid", 32'(out_valid), 32'd1);
                checkOutput("bp_data", 32'(out_data), 32'(prevData));
                checkOutput("bp_last", 32'(out_last), 32'(prevLast));
            end
            if (in_valid && in_ready) begin
                inMat[inCnt] = in_data;
                inCnt++;
                if (inCnt == NN) begin
                    pushMatrix();
                    inCnt = 0;
                end
            end
            if (out_valid) begin
                if (gapActive) begin
                    if (bubbleChk) checkOutput("bubble", 32'(gapCnt), 32'd1);
                    gapActive = 1'b0;
                end
                if (out_ready) begin
                    if (expData.size() == 0) begin
                        checkOutput("spurious_out", 32'(out_data), 32'hDEAD_BEEF);
                    end else begin
                        logic [DW-1:0] e;
                        logic el, eb;
                        e  = expData.pop_front();
                        el = expLast.pop_front();
                        eb = expByp.pop_front();
                        outCnt++;
                        checkOutput("out_data", 32'(out_data), 32'(e));
                        checkOutput("out_last", 32'(out_last), 32'(el));
`ifdef MAT_TRANS_CTRL_BYPASS_EN
                        checkOutput("bypass_active", 32'(bypass_active), 32'(eb));
`endif
                        if (el) begin
                            gapActive = 1'b1;
                            gapCnt    = 0;
                        end
                    end
                end
            end else if (gapActive) begin
                gapCnt++;
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
        end
        if (!bubbleChk) gapActive = 1'b0;
    end

    // Offer one element and hold it until the controller takes it; returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [DW-1:0] d);
        logic rdy;
        int   n;
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 300);
        if (!rdy) checkOutput("in_timeout", 32'd0, 32'd1);
    endtask

    task automatic sendMatrix(input mat_t m, input int maxGap);
        for (int i = 0; i < NN; i++) begin
            applyStimulus(m[i]);
            if (maxGap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, maxGap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n = 0;
        while ((expData.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 32'(n >= 1000), 32'd0);
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic mat_t randMatrix();
        mat_t m;
        for (int i = 0; i < NN; i++) m[i] = DW'($urandom);
        return m;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mat_t m;
        int   startCnt;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        readyMode = 0;
        bubbleChk = 1'b0;
        outCnt    = 0;
`ifdef MAT_TRANS_CTRL_BYPASS_EN
        cfg_bypass = 1'b0;
`endif
        #3;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
`ifdef MAT_TRANS_CTRL_BYPASS_EN
        checkOutput("rst_bypass_active", 32'(bypass_active), 32'd0);
`endif
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic transpose and latency");
        for (int i = 0; i < NN; i++) m[i] = DW'((i + 1) * 256);
        sendMatrix(m, 0);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_valid_k", 32'(out_valid), 32'd0);
        checkOutput("lat_full_ready", 32'(in_ready), 32'd0);
        checkOutput("lat_full_busy", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("lat_valid_k1", 32'(out_valid), 32'd1);
        checkOutput("first_out", 32'(out_data), 32'h0100);
        @(posedge clk);
        #1;
        drain();

        $display("[TB] back-pressure");
        readyMode = 1;
        sendMatrix(randMatrix(), 0);
        sendMatrix(randMatrix(), 0);
        in_valid = 1'b1;
        in_data  = DW'($urandom);
        repeat (3) begin
            @(negedge clk);
            checkOutput("full_in_ready", 32'(in_ready), 32'd0);
            checkOutput("full_busy", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        readyMode = 0;
        repeat (3) @(posedge clk);
        #1;
        readyMode = 1;
        repeat (5) @(posedge clk);
        #1;
        readyMode = 0;
        drain();

        $display("[TB] ping-pong");
        bubbleChk = 1'b1;
        startCnt  = outCnt;
        for (int f = 0; f < 3; f++) sendMatrix(randMatrix(), 0);
        drain();
        bubbleChk = 1'b0;
        checkOutput("pingpong_count", 32'(outCnt - startCnt), 32'(3 * NN));

        $display("[TB] reset mid-frame");
        readyMode = 1;
        sendMatrix(randMatrix(), 0);
        for (int i = 0; i < 5; i++) applyStimulus(DW'($urandom));
        in_valid = 1'b0;
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        readyMode = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        sendMatrix(randMatrix(), 0);
        drain();

        $display("[TB] negative values");
        for (int i = 0; i < NN; i++) m[i] = DW'(-(i + 1) * 256);
        startCnt = outCnt;
        sendMatrix(m, 0);
        drain();
        checkOutput("neg_count", 32'(outCnt - startCnt), 32'(NN));

`ifdef MAT_TRANS_CTRL_BYPASS_EN
        $display("[TB] bypass");
        cfg_bypass = 1'b1;
        sendMatrix(randMatrix(), 1);
        drain();
        cfg_bypass = 1'b0;
        sendMatrix(randMatrix(), 1);
        drain();
`endif

        $display("[TB] random traffic");
        readyMode = 2;
        for (int f = 0; f < 6; f++) sendMatrix(randMatrix(), 2);
        in_valid  = 1'b0;
        readyMode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
